// File: rtl/lab2_proc_pkg.sv
// rtl/lab2_proc_pkg.sv - shared types for the lab2 fetch front end
// Memory request/response message layouts and the fetch unit's internal
// in-flight and instruction-buffer entry types.
package lab2_proc_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } fetch_inflight_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_inst_t;

endpackage

// File: rtl/lab2_proc_fetch_inflight_queue.sv
// rtl/lab2_proc_fetch_inflight_queue.sv - in-order tracker of outstanding imem requests
// Ports: i_push/i_push_pc record a new request; i_pop retires the head;
// i_mark_stale marks every occupied entry stale; o_head_* describe the
// oldest request; o_live_count/o_total_count count non-stale/all entries.
module lab2_proc_fetch_inflight_queue
    import lab2_proc_pkg::*;
#(
    parameter int p_depth = 4,
    localparam int c_aw = $clog2(p_depth),
    localparam int c_cw = c_aw + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic [31:0]     i_push_pc,
    input  logic            i_pop,
    input  logic            i_mark_stale,
    output logic [31:0]     o_head_pc,
    output logic            o_head_stale,
    output logic            o_empty,
    output logic            o_full,
    output logic [c_cw-1:0] o_live_count,
    output logic [c_cw-1:0] o_total_count
);

    fetch_inflight_t  r_entries [p_depth];
    logic [c_aw-1:0]  r_head;
    logic [c_aw-1:0]  r_tail;
    logic [c_cw-1:0]  r_total;
    logic [c_cw-1:0]  r_live;
    logic [c_cw-1:0]  w_live_next;

    assign o_head_pc     = r_entries[r_head].pc;
    assign o_head_stale  = r_entries[r_head].stale;
    assign o_empty       = (r_total == '0);
    assign o_full        = (r_total == c_cw'(p_depth));
    assign o_live_count  = r_live;
    assign o_total_count = r_total;

    // Marking stale zeroes the live count even if the head pops this cycle;
    // a push in the same cycle is always live.
    always_comb begin
        w_live_next = r_live;
        if (i_mark_stale)
            w_live_next = '0;
        else if (i_pop && !o_head_stale)
            w_live_next = w_live_next - c_cw'(1);
        if (i_push)
            w_live_next = w_live_next + c_cw'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_total <= '0;
            r_live  <= '0;
            for (int i = 0; i < p_depth; i++) r_entries[i] <= '0;
        end else begin
            // Setting free slots stale is harmless: a push rewrites the bit.
            if (i_mark_stale)
                for (int i = 0; i < p_depth; i++) r_entries[i].stale <= 1'b1;
            if (i_push) begin
                r_entries[r_tail].pc    <= i_push_pc;
                r_entries[r_tail].stale <= 1'b0;
                r_tail                  <= r_tail + c_aw'(1);
            end
            if (i_pop) r_head <= r_head + c_aw'(1);
            r_total <= r_total + c_cw'(i_push) - c_cw'(i_pop);
            r_live  <= w_live_next;
        end
    end

endmodule

// File: rtl/vc_queue_bypass.sv
// rtl/vc_queue_bypass.sv - small FIFO with combinational enqueue-to-dequeue bypass
// Ports: i_flush empties the queue (an item dequeued in the same cycle is
// still delivered); i_enq_*/o_enq_rdy enqueue side; o_deq_*/i_deq_rdy
// dequeue side; o_count is the number of stored entries.
module vc_queue_bypass #(
    parameter int p_depth     = 2,
    parameter int p_msg_nbits = 64,
    localparam int c_pw = (p_depth > 1) ? $clog2(p_depth) : 1,
    localparam int c_cw = $clog2(p_depth + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_enq_val,
    output logic                   o_enq_rdy,
    input  logic [p_msg_nbits-1:0] i_enq_msg,
    output logic                   o_deq_val,
    input  logic                   i_deq_rdy,
    output logic [p_msg_nbits-1:0] o_deq_msg,
    output logic [c_cw-1:0]        o_count
);

    logic [p_msg_nbits-1:0] r_mem [p_depth];
    logic [c_pw-1:0]        r_head;
    logic [c_pw-1:0]        r_tail;
    logic [c_cw-1:0]        r_count;

    logic w_empty;
    logic w_enq;
    logic w_deq;
    logic w_bypass;

    function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_pw'(p_depth - 1)) ? '0 : p + c_pw'(1);
    endfunction

    assign w_empty   = (r_count == '0);
    assign o_enq_rdy = (r_count != c_cw'(p_depth));
    assign o_deq_val = !w_empty || i_enq_val;
    assign o_deq_msg = w_empty ? i_enq_msg : r_mem[r_head];
    assign o_count   = r_count;

    assign w_enq    = i_enq_val && o_enq_rdy;
    assign w_deq    = o_deq_val && i_deq_rdy;
    // An item passing straight through an empty queue never touches storage.
    assign w_bypass = w_empty && w_enq && w_deq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < p_depth; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq && !w_bypass) begin
                r_mem[r_tail] <= i_enq_msg;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_deq && !w_bypass) r_head <= ptr_inc(r_head);
            r_count <= r_count + c_cw'(w_enq && !w_bypass) - c_cw'(w_deq && !w_bypass);
        end
    end

endmodule

// File: rtl/lab2_proc_fetch_unit.sv
// rtl/lab2_proc_fetch_unit.sv - pipelined-processor instruction fetch front end
// Ports: redirect_* restart fetch; imem_reqstream_* issue reads at pc_F;
// imem_respstream_* return instructions; inst_* deliver {inst, pc} to
// decode; inflight_count and drop_count expose outstanding/dropped totals.
module lab2_proc_fetch_unit
    import lab2_proc_pkg::*;
#(
    parameter int          p_max_inflight = 4,
    parameter int          p_buf_depth    = 2,
    parameter logic [31:0] p_reset_pc     = 32'h0000_0200,
    localparam int c_cw = $clog2(p_max_inflight) + 1,
    localparam int c_ow = $clog2(p_buf_depth + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_val,
    input  logic [31:0]     redirect_pc,
    output mem_req_4B_t     imem_reqstream_msg,
    output logic            imem_reqstream_val,
    input  logic            imem_reqstream_rdy,
    input  mem_resp_4B_t    imem_respstream_msg,
    input  logic            imem_respstream_val,
    output logic            imem_respstream_rdy,
    output logic [31:0]     inst_msg,
    output logic [31:0]     inst_pc,
    output logic            inst_val,
    input  logic            inst_rdy,
    output logic [c_cw-1:0] inflight_count,
    output logic [31:0]     drop_count
);

    logic [31:0]     r_pc_f;
    logic [31:0]     r_drop_count;
    logic            r_run;

    logic            w_req_fire;
    logic            w_resp_fire;
    logic            w_resp_keep;
    logic            w_resp_drop;
    logic            w_credit;
    logic [31:0]     w_head_pc;
    logic            w_head_stale;
    logic            w_if_empty;
    logic            w_if_full;
    logic [c_cw-1:0] w_live;
    logic [c_cw-1:0] w_total;
    logic [c_ow-1:0] w_out_count;
    logic            w_out_enq_rdy;
    fetch_inst_t     w_enq_inst;
    fetch_inst_t     w_deq_inst;
    logic            w_unused;

    assign w_unused = &{1'b0, imem_respstream_msg.type_, imem_respstream_msg.opaque,
                        imem_respstream_msg.test, imem_respstream_msg.len, w_out_enq_rdy};

    // Credit uses registered counts only, so inst_rdy never reaches the
    // request valid combinationally. Every live request already owns a
    // slot in the output buffer.
    assign w_credit = (int'(w_live) + int'(w_out_count)) < p_buf_depth;

    assign imem_reqstream_val = r_run && !redirect_val && !w_if_full && w_credit;
    assign imem_reqstream_msg = '{type_: MEM_TYPE_READ, opaque: 8'd0, addr: r_pc_f,
                                  len: 2'd0, data: 32'd0};
    assign w_req_fire         = imem_reqstream_val && imem_reqstream_rdy;

    assign imem_respstream_rdy = !w_if_empty;
    assign w_resp_fire         = imem_respstream_val && imem_respstream_rdy;
    assign w_resp_drop         = w_resp_fire && (w_head_stale || redirect_val);
    assign w_resp_keep         = w_resp_fire && !w_head_stale && !redirect_val;

    assign w_enq_inst = '{inst: imem_respstream_msg.data, pc: w_head_pc};

    assign inst_msg       = w_deq_inst.inst;
    assign inst_pc        = w_deq_inst.pc;
    assign inflight_count = w_total;
    assign drop_count     = r_drop_count;

    lab2_proc_fetch_inflight_queue #(
        .p_depth (p_max_inflight)
    ) u_inflight (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_req_fire),
        .i_push_pc     (r_pc_f),
        .i_pop         (w_resp_fire),
        .i_mark_stale  (redirect_val),
        .o_head_pc     (w_head_pc),
        .o_head_stale  (w_head_stale),
        .o_empty       (w_if_empty),
        .o_full        (w_if_full),
        .o_live_count  (w_live),
        .o_total_count (w_total)
    );

    vc_queue_bypass #(
        .p_depth     (p_buf_depth),
        .p_msg_nbits ($bits(fetch_inst_t))
    ) u_out_queue (
        .clk       (clk),
        .reset     (reset),
        .i_flush   (redirect_val),
        .i_enq_val (w_resp_keep),
        .o_enq_rdy (w_out_enq_rdy),
        .i_enq_msg (w_enq_inst),
        .o_deq_val (inst_val),
        .i_deq_rdy (inst_rdy),
        .o_deq_msg (w_deq_inst),
        .o_count   (w_out_count)
    );

    // r_run holds the request valid low until the first edge out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run        <= 1'b0;
            r_pc_f       <= p_reset_pc;
            r_drop_count <= 32'd0;
        end else begin
            r_run <= 1'b1;
            if (redirect_val)
                r_pc_f <= redirect_pc;
            else if (w_req_fire)
                r_pc_f <= r_pc_f + 32'd4;
            if (w_resp_drop)
                r_drop_count <= r_drop_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_lab2_proc_fetch_unit.sv
// tb/tb_lab2_proc_fetch_unit.sv - randomized scoreboard bench for lab2_proc_fetch_unit
module tb_lab2_proc_fetch_unit;
    import lab2_proc_pkg::*;

    localparam int          MAXI     = 4;
    localparam int          BUF      = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0200;

    logic         clk;
    logic         rst_n;
    logic         redirect_val;
    logic [31:0]  redirect_pc;
    mem_req_4B_t  req_msg;
    logic         req_val;
    logic         req_rdy;
    mem_resp_4B_t resp_msg;
    logic         resp_val;
    logic         resp_rdy;
    logic [31:0]  inst_msg;
    logic [31:0]  inst_pc;
    logic         inst_val;
    logic         inst_rdy;
    logic [2:0]   inflight_count;
    logic [31:0]  drop_count;

    lab2_proc_fetch_unit #(
        .p_max_inflight (MAXI),
        .p_buf_depth    (BUF),
        .p_reset_pc     (RESET_PC)
    ) dut (
        .clk                 (clk),
        .reset               (rst_n),
        .redirect_val        (redirect_val),
        .redirect_pc         (redirect_pc),
        .imem_reqstream_msg  (req_msg),
        .imem_reqstream_val  (req_val),
        .imem_reqstream_rdy  (req_rdy),
        .imem_respstream_msg (resp_msg),
        .imem_respstream_val (resp_val),
        .imem_respstream_rdy (resp_rdy),
        .inst_msg            (inst_msg),
        .inst_pc             (inst_pc),
        .inst_val            (inst_val),
        .inst_rdy            (inst_rdy),
        .inflight_count      (inflight_count),
        .drop_count          (drop_count)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    mreq_t       mem_q [$];
    exp_t        exp_q [$];
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          epoch     = 0;
    int          drops     = 0;
    int          last_due  = 0;
    logic [31:0] model_pc  = RESET_PC;
    logic        armed;

    int lat        = 1;   // 0 selects a random latency per request
    int rdy_pct    = 100;
    int req_rdy_pct = 100;
    int redir_pct  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Decode may only see traffic from the first edge after reset release.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        mem_q.delete();
        exp_q.delete();
        drops    = 0;
        last_due = 0;
        epoch    = epoch + 1;
        model_pc = RESET_PC;
    endtask

    // Driver: memory system, decode readiness and redirects.
    initial begin
        redirect_val = 1'b0;
        redirect_pc  = '0;
        req_rdy      = 1'b0;
        resp_val     = 1'b0;
        resp_msg     = '0;
        inst_rdy     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !armed) begin
                redirect_val = 1'b0;
                resp_val     = 1'b0;
                inst_rdy     = 1'b0;
                req_rdy      = 1'b0;
            end else begin
                redirect_val = ($urandom_range(0, 99) < redir_pct);
                redirect_pc  = $urandom & 32'h0000_fffc;
                inst_rdy     = ($urandom_range(0, 99) < rdy_pct);
                req_rdy      = ($urandom_range(0, 99) < req_rdy_pct);
                if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                    resp_val      = 1'b1;
                    resp_msg      = '0;
                    resp_msg.data = mem_data(mem_q[0].addr);
                end else begin
                    resp_val = 1'b0;
                end
            end
        end
    end

    // Monitor: compares the DUT against the reference model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                int   live;
                int   total;
                logic exp_req_val;
                total = mem_q.size();
                live  = 0;
                foreach (mem_q[i]) if (mem_q[i].ep == epoch) live++;
                exp_req_val = armed && !redirect_val && (total < MAXI) &&
                              (live + exp_q.size() < BUF);
                chk("req_val", req_val, exp_req_val);
                chk("resp_rdy", resp_rdy, total > 0);
                chk("inflight_count", inflight_count, total);
                chk("drop_count", drop_count, drops);

                if (resp_val && resp_rdy) begin
                    if (mem_q.size() == 0) begin
                        chk("resp_without_request", 1, 0);
                    end else begin
                        mreq_t h;
                        h = mem_q.pop_front();
                        if (h.ep != epoch || redirect_val) drops++;
                        else exp_q.push_back('{inst: mem_data(h.addr), pc: h.addr});
                    end
                end

                chk("inst_val", inst_val, exp_q.size() > 0);
                if (inst_val && inst_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_inst", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("inst_pc", inst_pc, e.pc);
                        chk("inst_msg", inst_msg, e.inst);
                    end
                end

                if (req_val && req_rdy) begin
                    int l;
                    int d;
                    chk("req_addr", req_msg.addr, model_pc);
                    chk("req_hdr", {req_msg.type_, req_msg.opaque, req_msg.len},
                        {MEM_TYPE_READ, 8'd0, 2'd0});
                    l = (lat > 0) ? lat : int'($urandom_range(1, 5));
                    d = cyc + l;
                    if (d < last_due) d = last_due;
                    last_due = d;
                    mem_q.push_back('{addr: model_pc, due: d, ep: epoch});
                    model_pc = model_pc + 32'd4;
                end

                if (redirect_val) begin
                    exp_q.delete();
                    epoch++;
                    model_pc = redirect_pc;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_val"}, req_val, 1'b0);
        chk({tag, "_inst_val"}, inst_val, 1'b0);
        chk({tag, "_resp_rdy"}, resp_rdy, 1'b0);
        chk({tag, "_inflight"}, inflight_count, 3'd0);
        chk({tag, "_drops"}, drop_count, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        #3 rst_n = 1'b1;

        // Plain stream: latency 1, decode always ready.
        lat = 1; rdy_pct = 100; req_rdy_pct = 100; redir_pct = 0;
        repeat (40) @(posedge clk);

        // Latency 3 with redirects over outstanding requests.
        lat = 3; redir_pct = 10;
        repeat (300) @(posedge clk);

        // Everything random, including back-to-back redirects.
        lat = 0; rdy_pct = 70; req_rdy_pct = 80; redir_pct = 12;
        repeat (600) @(posedge clk);

        // Decode backpressure: issue must stop once the buffer is spoken for.
        lat = 1; rdy_pct = 0; req_rdy_pct = 100; redir_pct = 0;
        repeat (30) @(posedge clk);
        rdy_pct = 100;
        repeat (20) @(posedge clk);

        // Reset with requests outstanding, then restart from the reset PC.
        lat = 4;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        lat = 1; rdy_pct = 100; redir_pct = 0;
        repeat (40) @(posedge clk);

        lat = 0; rdy_pct = 60; redir_pct = 8;
        repeat (300) @(posedge clk);

        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
